// File: rtl/ps2_pkg.sv
// ps2_pkg: Set 2 scancodes, HID codes, frame states and scancode translation
package ps2_pkg;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_NONE  = 8'h00;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_t;
  function automatic logic [7:0] sc2hid(input logic ext, input logic [7:0] code);
    return ext ? (code == SC_UP   ? KEY_UP   : code == SC_LEFT ? KEY_LEFT :
                  code == SC_DOWN ? KEY_DOWN : code == SC_RIGHT ? KEY_RIGHT : KEY_NONE)
               : (code == SC_W ? KEY_UP   : code == SC_A ? KEY_LEFT :
                  code == SC_S ? KEY_DOWN : code == SC_D ? KEY_RIGHT : KEY_NONE);
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 pin synchronizer, clock glitch filter and 11-bit frame receiver
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       timeout
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0] clk_s, data_s;
  logic fclk, par;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] idle_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  frame_state_t state;
  logic din, flip, samp, tmo;
  assign din  = data_s[1];
  // the filtered clock flips on the FILTER_LEN-th consecutive differing sample
  assign flip = clk_s[1] != fclk && fcnt == FW'(FILTER_LEN - 1);
  assign samp = flip && fclk;
  assign tmo  = state != ST_IDLE && !samp && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s      <= '0;
      data_s     <= '0;
      fclk       <= 1'b0;
      fcnt       <= '0;
      idle_cnt   <= '0;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      clk_s      <= {clk_s[0], ps2_clk};
      data_s     <= {data_s[0], ps2_data};
      fcnt       <= (clk_s[1] == fclk || flip) ? '0 : fcnt + 1'b1;
      fclk       <= flip ? clk_s[1] : fclk;
      idle_cnt   <= (samp || tmo || state == ST_IDLE) ? '0 : idle_cnt + 1'b1;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      if (tmo) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        timeout   <= 1'b1;
      end else if (samp) begin
        case (state)
          ST_IDLE: if (!din) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
          ST_DATA: begin
            shift   <= {din, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            state   <= bit_cnt == 3'd7 ? ST_PARITY : ST_DATA;
          end
          ST_PARITY: begin
            par   <= din;
            state <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (din && ^{shift, par}) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else frame_err <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 keyboard to single held-key HID keycode for the game core
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_valid,
  output logic       err
);
  logic [7:0] byte_data, hid;
  logic byte_valid, timeout, ext, brk;
  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_data(byte_data), .byte_valid(byte_valid), .frame_err(err), .timeout(timeout)
  );
  assign hid = sc2hid(ext, byte_data);
  always_ff @(posedge clk) begin
    if (rst) begin
      keycode   <= KEY_NONE;
      key_valid <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == SC_EXT) ext <= 1'b1;
        else if (byte_data == SC_BRK) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          // a break only releases the key currently tracked
          if (hid != KEY_NONE && !brk) begin
            keycode   <= hid;
            key_valid <= hid != keycode;
          end else if (hid != KEY_NONE && hid == keycode) begin
            keycode   <= KEY_NONE;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule
